// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared encodings and branch decision for the fetch unit
package fetch_pkg;

    typedef enum logic [1:0] {
        BR_BEQ  = 2'b00,
        BR_BNE  = 2'b01,
        BR_JMP  = 2'b10,
        BR_NONE = 2'b11
    } br_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DROP = 2'b10
    } fetch_state_e;

    function automatic logic branch_taken(input logic en, input logic [1:0] mode, input logic z);
        logic t;
        t = 1'b0;
        case (br_mode_e'(mode))
            BR_BEQ:  t = z;
            BR_BNE:  t = !z;
            BR_JMP:  t = 1'b1;
            default: t = 1'b0;
        endcase
        return en && t;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small power-of-two FIFO holding {pc, instruction} entries
module fetch_queue #(
    parameter int W     = 64,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_push_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic          o_valid,
    output logic [W-1:0]  o_head,
    output logic [CW-1:0] o_count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_valid;
    logic          w_pop;
    logic [CW-1:0] w_count_nxt;

    assign w_pop       = i_pop && r_valid;
    assign w_count_nxt = r_count + CW'(i_push) - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (rst && !i_flush && i_push) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    // Flush discards everything, including a same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (!rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
        end
    end

    assign o_valid = r_valid;
    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetcher with branch redirect and flush
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int           AW       = 32,
    parameter int           DW       = 32,
    parameter int           STEP     = 4,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int           QDEPTH   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          br_en,
    input  logic [1:0]    br_mode,
    input  logic          z,
    input  logic [AW-1:0] b_addr,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [DW-1:0] imem_rdata,
    output logic          inst_valid,
    output logic [DW-1:0] inst,
    output logic [AW-1:0] inst_pc,
    input  logic          inst_ready,
    output logic [AW-1:0] addr
);
    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_e     r_state;
    logic [AW-1:0]    r_pc;
    logic [AW-1:0]    r_req_pc;
    logic             w_taken;
    logic             w_push;
    logic [CW-1:0]    w_count;
    logic [AW+DW-1:0] w_head;

    assign w_taken   = branch_taken(br_en, br_mode, z);
    assign imem_req  = rst && (r_state == ST_IDLE) && !stall && !w_taken && (w_count < CW'(QDEPTH));
    assign imem_addr = r_pc;
    assign addr      = r_pc;
    assign w_push    = (r_state == ST_WAIT) && imem_rvalid && !w_taken;

    // A redirect always wins over the sequential increment; responses owed
    // to a squashed request are swallowed in DROP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
        end else begin
            if (w_taken) r_pc <= b_addr;
            case (r_state)
                ST_IDLE: begin
                    if (imem_req && imem_gnt) begin
                        r_pc     <= r_pc + AW'(STEP);
                        r_req_pc <= r_pc;
                        r_state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid)  r_state <= ST_IDLE;
                    else if (w_taken) r_state <= ST_DROP;
                end
                ST_DROP: begin
                    if (imem_rvalid) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    fetch_queue #(
        .W     (AW + DW),
        .DEPTH (QDEPTH),
        .CW    (CW)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data ({r_req_pc, imem_rdata}),
        .i_pop       (inst_ready),
        .i_flush     (w_taken),
        .o_valid     (inst_valid),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign inst    = w_head[DW-1:0];
    assign inst_pc = w_head[AW+DW-1:DW];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized checks of fetch_unit against a queue-level model
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst, stall, br_en, z, gnt, rvalid, ready;
    logic [1:0]  mode;
    logic [31:0] b_addr, rdata;
    logic        imem_req, inst_valid;
    logic [31:0] imem_addr, inst, inst_pc, addr;
    logic [7:0]  b_addr8, iaddr8, ipc8, addr8;
    logic        req8, iv8;
    logic [31:0] inst8;

    int total = 0;
    int bad = 0;
    int grants = 0;
    logic [31:0] last_gaddr = '0;
    logic [31:0] popped [$];
    logic [31:0] saved;

    // Reference model: PC, one outstanding request, drop flag, and a plain queue.
    logic [31:0] m_pc = '0;
    logic [31:0] m_rpc = '0;
    bit          m_busy = 0;
    bit          m_drop = 0;
    logic [31:0] m_qp [$];
    logic [31:0] m_qd [$];

    assign b_addr8 = b_addr[7:0];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .br_en(br_en), .br_mode(mode), .z(z),
        .b_addr(b_addr), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(gnt),
        .imem_rvalid(rvalid), .imem_rdata(rdata), .inst_valid(inst_valid), .inst(inst),
        .inst_pc(inst_pc), .inst_ready(ready), .addr(addr)
    );

    fetch_unit #(.AW(8), .DW(32), .STEP(4), .RESET_PC(8'h00), .QDEPTH(2)) dut8 (
        .clk(clk), .rst(rst), .stall(stall), .br_en(br_en), .br_mode(mode), .z(z),
        .b_addr(b_addr8), .imem_req(req8), .imem_addr(iaddr8), .imem_gnt(gnt),
        .imem_rvalid(rvalid), .imem_rdata(rdata), .inst_valid(iv8), .inst(inst8),
        .inst_pc(ipc8), .inst_ready(ready), .addr(addr8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit tk, er, pop;
        @(negedge clk);
        #1;
        tk = rst && br_en && ((mode == 2'b00 && z) || (mode == 2'b01 && !z) || mode == 2'b10);
        er = rst && !m_busy && !stall && !tk && (m_qp.size() < 2);
        chk("imem_req", imem_req, er);
        chk("addr", addr, m_pc);
        chk("imem_addr", imem_addr, m_pc);
        chk("addr8", addr8, m_pc[7:0]);
        chk("inst_valid", inst_valid, m_qp.size() != 0);
        if (m_qp.size() != 0) begin
            chk("inst_pc", inst_pc, m_qp[0]);
            chk("inst", inst, m_qd[0]);
        end
        if (imem_req && gnt) begin
            grants++;
            last_gaddr = imem_addr;
        end
        if (inst_valid && ready) popped.push_back(inst_pc);
        pop = ready && (m_qp.size() != 0);
        @(posedge clk);
        if (!rst) begin
            m_pc = '0; m_busy = 0; m_drop = 0;
            m_qp.delete(); m_qd.delete();
        end else if (tk) begin
            m_pc = b_addr;
            m_qp.delete(); m_qd.delete();
            if (m_busy) begin
                if (rvalid) begin m_busy = 0; m_drop = 0; end
                else m_drop = 1;
            end
        end else begin
            if (pop) begin void'(m_qp.pop_front()); void'(m_qd.pop_front()); end
            if (m_busy && rvalid) begin
                if (!m_drop) begin m_qp.push_back(m_rpc); m_qd.push_back(rdata); end
                m_busy = 0; m_drop = 0;
            end
            if (er && gnt) begin m_rpc = m_pc; m_pc = m_pc + 32'd4; m_busy = 1; end
        end
        #1;
    endtask

    initial begin
        rst = 0; stall = 0; br_en = 0; mode = 2'b11; z = 0; b_addr = '0;
        gnt = 0; rvalid = 0; rdata = '0; ready = 0;
        step(); step();
        chk("reset_addr", addr, 32'h0);
        chk("reset_valid", inst_valid, 1'b0);
        rst = 1;

        // Back-to-back fetch with a consumer that is always ready.
        gnt = 1; rvalid = 1; ready = 1;
        popped.delete();
        for (int i = 0; i < 8; i++) begin rdata = $urandom; step(); end
        chk("seq_count_ok", popped.size() >= 3, 1'b1);
        if (popped.size() >= 3) begin
            chk("seq_pc0", popped[0], 32'h0);
            chk("seq_pc1", popped[1], 32'h4);
            chk("seq_pc2", popped[2], 32'h8);
        end

        // Backpressure: the queue fills at two entries and fetching stops.
        rst = 0; step(); rst = 1;
        ready = 0; grants = 0;
        for (int i = 0; i < 8; i++) begin rdata = $urandom; step(); end
        chk("bp_grants", grants, 2);
        chk("bp_req_low", imem_req, 1'b0);
        chk("bp_addr", addr, 32'h8);
        ready = 1; grants = 0;
        for (int i = 0; i < 6 && grants == 0; i++) begin rdata = $urandom; step(); end
        chk("bp_resumed", grants != 0, 1'b1);
        chk("bp_resume_addr", last_gaddr, 32'h8);

        // Taken beq while waiting: the late response is dropped.
        rst = 0; step(); rst = 1;
        gnt = 1; rvalid = 0;
        step();
        gnt = 0; br_en = 1; mode = 2'b00; z = 1; b_addr = 32'h100;
        step();
        br_en = 0; rvalid = 1; rdata = 32'hDEAD_BEEF;
        step();
        rvalid = 0; gnt = 1;
        #1;
        chk("drop_empty", inst_valid, 1'b0);
        chk("drop_req", imem_req, 1'b1);
        chk("drop_addr", imem_addr, 32'h100);

        // bne with z=1 is not taken; jump with z=0 is.
        br_en = 1; mode = 2'b01; z = 1; b_addr = 32'h40;
        step();
        chk("bne_nt_addr", addr, 32'h104);
        gnt = 0; rvalid = 1; rdata = $urandom; mode = 2'b10; z = 0;
        step();
        chk("jmp_addr", addr, 32'h40);
        chk("jmp_empty", inst_valid, 1'b0);

        // Wraparound on the 8-bit instance.
        ready = 0; rvalid = 0; mode = 2'b10; b_addr = 32'hFC;
        step();
        br_en = 0; gnt = 1;
        step();
        chk("wrap_addr8", addr8, 8'h00);
        chk("wrap_addr32", addr, 32'h100);
        gnt = 0; rvalid = 1; rdata = $urandom;
        step();

        // Stall holds issue; reset during WAIT restarts cleanly.
        rvalid = 0; gnt = 1; stall = 1;
        saved = addr;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_req", imem_req, 1'b0);
            chk("stall_addr", addr, saved);
        end
        stall = 0;
        step();
        gnt = 0; rst = 0;
        step();
        chk("rst_wait_addr", addr, 32'h0);
        chk("rst_wait_valid", inst_valid, 1'b0);
        rst = 1; rvalid = 1;
        step();
        chk("late_resp_ignored", inst_valid, 1'b0);

        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 39) != 0);
            stall  = ($urandom_range(0, 3) == 0);
            br_en  = ($urandom_range(0, 5) == 0);
            mode   = 2'($urandom);
            z      = 1'($urandom);
            b_addr = $urandom & 32'hFFFF_FFFC;
            gnt    = ($urandom_range(0, 3) != 0);
            rvalid = 1'($urandom);
            rdata  = $urandom;
            ready  = 1'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
